write_logic_param: RTL and testbench

Parametrised write-side pointer logic for the line-based packet buffer, the successor to the fixed 4-line/2048-char write logic. It maintains the character offset within the current line and the line index plus wrap bit. It detects buffer-full against the read side's line pointer, flags and discards over-length lines, and reports the length of each committed line. It sits between the ingress framer, which issues newline/restart/char-increment, and the dual-port line RAM.

---
 rtl/write_logic_param.sv | 166 ++++++++++++++++
 tb/tb_write_logic_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/write_logic_param.sv
`default_nettype none
// ============================================================================
// Module   : write_logic_param
// Purpose  : Write-side pointer logic for a line-based packet buffer.
//            Tracks the character offset inside the current line and the
//            line index (with wrap bit), detects buffer-full against the
//            reader's line pointer, discards over-length lines and reports
//            the length of each committed line.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            wr_newline           - commit current line, advance to next
//            wr_restart_line      - abort current line (offset back to 0)
//            wr_char_incr         - character written at wr_ptr this cycle
//            rd_line_tribit       - reader line index, wrap bit in MSB
//            wr_ptr               - RAM write address {line, offset}
//            wr_line_tribit       - {wrap bit, line index}
//            wr_allow             - writer may write RAM this cycle
//            buf_full             - current line still owned by reader
//            line_overflow        - sticky, line exceeded 2^CHAR_W chars
//            wr_len/wr_len_valid  - length of last committed line + pulse
//            wr_drop              - pulse, over-length line discarded
//            stat_commit/stat_drop- saturating event counters (optional)
// Options  : WRL_LINE_STATS_EN adds the stat_commit/stat_drop counters.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module write_logic_param #(
   parameter int CHAR_W = 11,
   parameter int LINE_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_newline,
   input  logic                     wr_restart_line,
   input  logic                     wr_char_incr,
   input  logic [LINE_W:0]          rd_line_tribit,
   output logic [CHAR_W+LINE_W-1:0] wr_ptr,
   output logic [LINE_W:0]          wr_line_tribit,
   output logic                     wr_allow,
   output logic                     buf_full,
   output logic                     line_overflow,
   output logic [CHAR_W:0]          wr_len,
   output logic                     wr_len_valid,
   output logic                     wr_drop
`ifdef WRL_LINE_STATS_EN
   ,
   output logic [15:0]              stat_commit,
   output logic [15:0]              stat_drop
`endif
);

   localparam logic [CHAR_W:0] c_cnt_zero = '0;
   localparam logic [CHAR_W:0] c_cnt_one  = {{CHAR_W{1'b0}}, 1'b1};
   localparam logic [LINE_W:0] c_line_one = {{LINE_W{1'b0}}, 1'b1};

   logic [CHAR_W:0] cnt_q,    cnt_d;
   logic [LINE_W:0] line_q,   line_d;
   logic            ovf_q,    ovf_d;
   logic [CHAR_W:0] len_q,    len_d;
   logic            len_vld_q, len_vld_d;
   logic            drop_q,   drop_d;

   logic w_full;
   logic w_allow;
   logic w_cnt_at_max;

   // The reader owns the line when indices match but wrap bits differ,
   // i.e. the writer has lapped the reader by a whole ring.
   assign w_full = (line_q[LINE_W-1:0] == rd_line_tribit[LINE_W-1:0]) &&
                   (line_q[LINE_W]     != rd_line_tribit[LINE_W]);

   // cnt never exceeds 2^CHAR_W, so its MSB alone marks a full line.
   assign w_cnt_at_max = cnt_q[CHAR_W];
   assign w_allow      = !w_full && !w_cnt_at_max && !ovf_q;

   // Priority: restart > newline > char_incr. An asserted higher-priority
   // event masks the lower ones even when it is itself ignored.
   always_comb begin
      cnt_d     = cnt_q;
      line_d    = line_q;
      ovf_d     = ovf_q;
      len_d     = len_q;
      len_vld_d = 1'b0;
      drop_d    = 1'b0;
      if (wr_restart_line) begin
         cnt_d = c_cnt_zero;
         ovf_d = 1'b0;
      end else if (wr_newline) begin
         if (w_full) begin
            // reader still owns this line: nothing may change
         end else if (ovf_q) begin
            cnt_d  = c_cnt_zero;
            ovf_d  = 1'b0;
            drop_d = 1'b1;
         end else if (cnt_q != c_cnt_zero) begin
            len_d     = cnt_q;
            len_vld_d = 1'b1;
            cnt_d     = c_cnt_zero;
            line_d    = line_q + c_line_one;
         end
      end else if (wr_char_incr) begin
         if (w_allow) begin
            cnt_d = cnt_q + c_cnt_one;
         end else if (!w_full && w_cnt_at_max) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         line_q    <= '0;
         ovf_q     <= 1'b0;
         len_q     <= '0;
         len_vld_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         line_q    <= line_d;
         ovf_q     <= ovf_d;
         len_q     <= len_d;
         len_vld_q <= len_vld_d;
         drop_q    <= drop_d;
      end
   end

   assign wr_ptr         = {line_q[LINE_W-1:0], cnt_q[CHAR_W-1:0]};
   assign wr_line_tribit = line_q;
   assign wr_allow       = w_allow;
   assign buf_full       = w_full;
   assign line_overflow  = ovf_q;
   assign wr_len         = len_q;
   assign wr_len_valid   = len_vld_q;
   assign wr_drop        = drop_q;

`ifdef WRL_LINE_STATS_EN
   logic [15:0] stat_commit_q, stat_commit_d;
   logic [15:0] stat_drop_q,   stat_drop_d;

   // Counted on the same edge that raises the corresponding pulse.
   always_comb begin
      stat_commit_d = stat_commit_q;
      stat_drop_d   = stat_drop_q;
      if (len_vld_d && (stat_commit_q != 16'hFFFF)) begin
         stat_commit_d = stat_commit_q + 16'd1;
      end
      if (drop_d && (stat_drop_q != 16'hFFFF)) begin
         stat_drop_d = stat_drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_commit_q <= '0;
         stat_drop_q   <= '0;
      end else begin
         stat_commit_q <= stat_commit_d;
         stat_drop_q   <= stat_drop_d;
      end
   end

   assign stat_commit = stat_commit_q;
   assign stat_drop   = stat_drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_write_logic_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_logic_param
// Purpose  : Self-checking bench for write_logic_param (CHAR_W=11, LINE_W=2).
//            Expected outputs are queued when stimulus is driven and compared
//            one cycle later after the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_logic_param;

   typedef struct {
      logic [12:0] ptr;
      logic [2:0]  tribit;
      logic        full;
      logic        allow;
      logic        ovf;
      logic [11:0] len;
      logic        lv;
      logic        drop;
   } exp_t;

   typedef struct {
      logic       r;
      logic       n;
      logic       c;
      logic [2:0] rd;
      exp_t       e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_newline = 1'b0;
   logic        wr_restart_line = 1'b0;
   logic        wr_char_incr = 1'b0;
   logic [2:0]  rd_line_tribit = 3'd0;
   logic [12:0] wr_ptr;
   logic [2:0]  wr_line_tribit;
   logic        wr_allow;
   logic        buf_full;
   logic        line_overflow;
   logic [11:0] wr_len;
   logic        wr_len_valid;
   logic        wr_drop;
`ifdef WRL_LINE_STATS_EN
   logic [15:0] stat_commit;
   logic [15:0] stat_drop;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   exp_t sb_q[$];
   vec_t tbl[0:16];

   always #5 clk = ~clk;

   write_logic_param #(.CHAR_W(11), .LINE_W(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .wr_newline      (wr_newline),
      .wr_restart_line (wr_restart_line),
      .wr_char_incr    (wr_char_incr),
      .rd_line_tribit  (rd_line_tribit),
      .wr_ptr          (wr_ptr),
      .wr_line_tribit  (wr_line_tribit),
      .wr_allow        (wr_allow),
      .buf_full        (buf_full),
      .line_overflow   (line_overflow),
      .wr_len          (wr_len),
      .wr_len_valid    (wr_len_valid),
      .wr_drop         (wr_drop)
`ifdef WRL_LINE_STATS_EN
      ,
      .stat_commit     (stat_commit),
      .stat_drop       (stat_drop)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cmp_exp(input string tag, input exp_t e);
      check({tag, ".wr_ptr"},         32'(wr_ptr),         32'(e.ptr));
      check({tag, ".wr_line_tribit"}, 32'(wr_line_tribit), 32'(e.tribit));
      check({tag, ".buf_full"},       32'(buf_full),       32'(e.full));
      check({tag, ".wr_allow"},       32'(wr_allow),       32'(e.allow));
      check({tag, ".line_overflow"},  32'(line_overflow),  32'(e.ovf));
      check({tag, ".wr_len"},         32'(wr_len),         32'(e.len));
      check({tag, ".wr_len_valid"},   32'(wr_len_valid),   32'(e.lv));
      check({tag, ".wr_drop"},        32'(wr_drop),        32'(e.drop));
   endtask

   function automatic vec_t mk(input logic r, n, c, input logic [2:0] rd,
                               input logic [12:0] ptr, input logic [2:0] tribit,
                               input logic full, allow, ovf,
                               input logic [11:0] len, input logic lv, drop);
      vec_t v;
      v.r = r; v.n = n; v.c = c; v.rd = rd;
      v.e.ptr = ptr; v.e.tribit = tribit; v.e.full = full; v.e.allow = allow;
      v.e.ovf = ovf; v.e.len = len; v.e.lv = lv; v.e.drop = drop;
      return v;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input string tag, input vec_t v);
      exp_t e;
      wr_restart_line = v.r;
      wr_newline      = v.n;
      wr_char_incr    = v.c;
      rd_line_tribit  = v.rd;
      sb_q.push_back(v.e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      cmp_exp(tag, e);
   endtask

   initial begin
      // reset-state check, newline at empty line, 5 chars, commit, fill ring
      tbl[0]  = mk(0,1,0,3'd0, 13'h0000,3'd0,0,1,0,12'd0,0,0);
      tbl[1]  = mk(0,0,1,3'd0, 13'h0001,3'd0,0,1,0,12'd0,0,0);
      tbl[2]  = mk(0,0,1,3'd0, 13'h0002,3'd0,0,1,0,12'd0,0,0);
      tbl[3]  = mk(0,0,1,3'd0, 13'h0003,3'd0,0,1,0,12'd0,0,0);
      tbl[4]  = mk(0,0,1,3'd0, 13'h0004,3'd0,0,1,0,12'd0,0,0);
      tbl[5]  = mk(0,0,1,3'd0, 13'h0005,3'd0,0,1,0,12'd0,0,0);
      tbl[6]  = mk(0,1,0,3'd0, 13'h0800,3'd1,0,1,0,12'd5,1,0);
      tbl[7]  = mk(0,0,0,3'd0, 13'h0800,3'd1,0,1,0,12'd5,0,0);
      tbl[8]  = mk(0,0,1,3'd0, 13'h0801,3'd1,0,1,0,12'd5,0,0);
      tbl[9]  = mk(0,1,0,3'd0, 13'h1000,3'd2,0,1,0,12'd1,1,0);
      tbl[10] = mk(0,0,1,3'd0, 13'h1001,3'd2,0,1,0,12'd1,0,0);
      tbl[11] = mk(0,1,0,3'd0, 13'h1800,3'd3,0,1,0,12'd1,1,0);
      tbl[12] = mk(0,0,1,3'd0, 13'h1801,3'd3,0,1,0,12'd1,0,0);
      tbl[13] = mk(0,1,0,3'd0, 13'h0000,3'd4,1,0,0,12'd1,1,0);
      tbl[14] = mk(0,0,1,3'd0, 13'h0000,3'd4,1,0,0,12'd1,0,0);
      tbl[15] = mk(0,1,0,3'd0, 13'h0000,3'd4,1,0,0,12'd1,0,0);
      tbl[16] = mk(0,0,0,3'd1, 13'h0000,3'd4,0,1,0,12'd1,0,0);

      repeat (2) @(posedge clk);
      #1;
      cmp_exp("reset", mk(0,0,0,3'd0, 13'h0,3'd0,0,1,0,12'd0,0,0).e);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) apply($sformatf("tbl%0d", i), tbl[i]);

      // over-length line: 2048 accepted, 2049th sets overflow, newline drops
      for (int i = 1; i <= 2048; i++)
         apply("ovf_fill", mk(0,0,1,3'd1, 13'(i % 2048),3'd4,0,(i < 2048),0,12'd1,0,0));
      apply("ovf_set",  mk(0,0,1,3'd1, 13'h0000,3'd4,0,0,1,12'd1,0,0));
      apply("ovf_hold", mk(0,0,1,3'd1, 13'h0000,3'd4,0,0,1,12'd1,0,0));
      apply("ovf_drop", mk(0,1,0,3'd1, 13'h0000,3'd4,0,1,0,12'd1,0,1));
      apply("ovf_idle", mk(0,0,0,3'd1, 13'h0000,3'd4,0,1,0,12'd1,0,0));

      // exactly full line commits with length 2048; new line is then full
      for (int i = 1; i <= 2048; i++)
         apply("max_fill", mk(0,0,1,3'd1, 13'(i % 2048),3'd4,0,(i < 2048),0,12'd1,0,0));
      apply("max_commit", mk(0,1,0,3'd1, 13'h0800,3'd5,1,0,0,12'h800,1,0));
      apply("max_free",   mk(0,0,0,3'd5, 13'h0800,3'd5,0,1,0,12'h800,0,0));

      // restart outranks newline and char_incr; empty newline ignored
      for (int i = 1; i <= 3; i++)
         apply("rs_chars", mk(0,0,1,3'd5, 13'(32'h800 + i),3'd5,0,1,0,12'h800,0,0));
      apply("rs_all", mk(1,1,1,3'd5, 13'h0800,3'd5,0,1,0,12'h800,0,0));
      apply("rs_nl0", mk(0,1,0,3'd5, 13'h0800,3'd5,0,1,0,12'h800,0,0));

      // move to line index 2, write 7 chars, then async reset mid-cycle
      apply("ar_c",  mk(0,0,1,3'd5, 13'h0801,3'd5,0,1,0,12'h800,0,0));
      apply("ar_nl", mk(0,1,0,3'd5, 13'h1000,3'd6,0,1,0,12'd1,1,0));
      for (int i = 1; i <= 7; i++)
         apply("ar_chars", mk(0,0,1,3'd5, 13'(32'h1000 + i),3'd6,0,1,0,12'd1,0,0));
      wr_char_incr = 1'b0;
`ifdef WRL_LINE_STATS_EN
      check("stat_commit", 32'(stat_commit), 32'd6);
      check("stat_drop",   32'(stat_drop),   32'd1);
`endif
      #3 rst = 1'b1;
      #1;
      cmp_exp("async_rst", mk(0,0,0,3'd5, 13'h0,3'd0,0,1,0,12'd0,0,0).e);
`ifdef WRL_LINE_STATS_EN
      check("stat_commit_rst", 32'(stat_commit), 32'd0);
      check("stat_drop_rst",   32'(stat_drop),   32'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      apply("post_rst", mk(0,0,1,3'd5, 13'h0001,3'd0,0,1,0,12'd0,0,0));
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
